// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one 8-bit ALU (FWD/ADD/AND/OR behind a 3-bit select) between two
// requesters. One request is granted at a time with round-robin priority. The
// winner's operands and select are registered into the ALU. They are held for
// SETTLE_CYCLES clocks so the ALU's combinational paths can resolve. The
// result is then captured and returned as a one-cycle response pulse to the
// granted requester. Illegal selects (op[2]=1) never reach the ALU. They are
// answered one cycle after accept with rsp_err set.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   req_valid    in   [1:0] request valid, bit i = requester i
//   req_ready    out  [1:0] request accept, bit i = requester i
//   req_op0/1    in   [2:0] ALU select per requester (1xx illegal)
//   req_a0/b0    in   [DATA_W-1:0] operands of requester 0
//   req_a1/b1    in   [DATA_W-1:0] operands of requester 1
//   alu_data1/2  out  [DATA_W-1:0] registered ALU operands
//   alu_select   out  [2:0] registered ALU select
//   alu_result   in   [DATA_W-1:0] combinational ALU result
//   rsp_valid    out  [1:0] one-cycle response pulse, bit i = requester i
//   rsp_result   out  [DATA_W-1:0] captured result, holds after the pulse
//   rsp_err      out  high with rsp_valid when the op was illegal
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned DATA_W        = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2:0]        req_op0,
    input  logic [2:0]        req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [2:0]        alu_select,
    input  logic [DATA_W-1:0] alu_result,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter preset so that it reads zero on the SETTLE_CYCLES-th edge after accept.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              ptr;     // requester favoured when both are valid
    logic              owner;   // requester currently being served

    logic              gnt_any;
    logic              gnt_idx;
    logic [2:0]        gnt_op;
    logic [DATA_W-1:0] gnt_a;
    logic [DATA_W-1:0] gnt_b;

    // Grant selection (combinational, only meaningful in IDLE)
    always_comb begin
        gnt_any = |req_valid;
        if (&req_valid) begin
            gnt_idx = ptr;
        end else begin
            gnt_idx = req_valid[1];
        end
        gnt_op = gnt_idx ? req_op1 : req_op0;
        gnt_a  = gnt_idx ? req_a1  : req_a0;
        gnt_b  = gnt_idx ? req_b1  : req_b0;
    end

    // Ready is also forced low while reset is held so every output reads zero.
    always_comb begin
        req_ready = 2'b00;
        if (reset_n && (state == ST_IDLE) && gnt_any) begin
            req_ready = gnt_idx ? 2'b10 : 2'b01;
        end
    end

    // Arbitration FSM, ALU operand registers and response capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            alu_data1  <= '0;
            alu_data2  <= '0;
            alu_select <= 3'b000;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        ptr   <= ~gnt_idx;
                        owner <= gnt_idx;
                        if (gnt_op[2]) begin
                            // Illegal select: answer at once, leave the ALU untouched.
                            state      <= ST_DONE;
                            rsp_valid  <= gnt_idx ? 2'b10 : 2'b01;
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                        end else begin
                            state      <= ST_WAIT;
                            cnt        <= CNT_INIT;
                            alu_data1  <= gnt_a;
                            alu_data2  <= gnt_b;
                            alu_select <= gnt_op;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= ST_DONE;
                        rsp_valid  <= owner ? 2'b10 : 2'b01;
                        rsp_result <= alu_result;
                        rsp_err    <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 2'b00;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 2'b00;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
